// File: rtl/ctrl_pipe.sv
// ctrl_pipe: valid/control pipeline with per-stage stall, flush, bubble insertion and field pruning
module ctrl_pipe #(
  parameter int W = 17,
  parameter int STAGES = 3,
  parameter logic [STAGES*W-1:0] KEEP_MASK = '1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [W-1:0]              in_ctrl,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES*W-1:0]       stage_ctrl,
  output logic                      retire,
  output logic [$clog2(STAGES+1)-1:0] inflight
);
  localparam int CW = $clog2(STAGES+1);
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES*W-1:0] ctrl_q, ctrl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic sv, us;
    logic [W-1:0] sc;
    if (k == 0) begin : g_head
      assign sv = in_valid;
      assign sc = in_ctrl;
      assign us = 1'b0;
    end else begin : g_body
      assign sv = valid_q[k-1];
      assign sc = ctrl_q[(k-1)*W +: W];
      assign us = stall[k-1];
    end
    // invalid sources and bubbles both zero the control so write enables never leak
    assign valid_d[k] = flush[k] ? 1'b0 : stall[k] ? valid_q[k] : us ? 1'b0 : sv;
    assign ctrl_d[k*W +: W] = flush[k] ? '0 : stall[k] ? ctrl_q[k*W +: W] :
                              (us | ~sv) ? '0 : sc & KEEP_MASK[k*W +: W];
  end
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < STAGES; i++) cnt_d = cnt_d + CW'(valid_d[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end
  // a running stage behind a stalled one silently drops its instruction
  if (STAGES > 1) begin : g_chk
    assert property (@(posedge clk) disable iff (rst)
      (stall[STAGES-1:1] & ~stall[STAGES-2:0]) == '0)
      else $error("ctrl_pipe: downstream stalled while upstream runs");
  end
  assign stage_valid = valid_q;
  assign stage_ctrl  = ctrl_q;
  assign inflight    = cnt_q;
  assign retire      = valid_q[STAGES-1] & ~stall[STAGES-1];
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed checks of ctrl_pipe with default and pruned keep masks
module tb_ctrl_pipe;
  logic clk = 1'b0;
  logic rst, in_valid;
  logic [7:0] in_ctrl;
  logic [2:0] stall, flush;
  logic [2:0] a_valid, b_valid;
  logic [23:0] a_ctrl, b_ctrl;
  logic a_retire, b_retire;
  logic [1:0] a_inflight, b_inflight;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ctrl_pipe #(.W(8), .STAGES(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .stall(stall), .flush(flush), .stage_valid(a_valid), .stage_ctrl(a_ctrl),
    .retire(a_retire), .inflight(a_inflight));
  ctrl_pipe #(.W(8), .STAGES(3), .KEEP_MASK(24'h0FFFFF)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .stall(stall), .flush(flush), .stage_valid(b_valid), .stage_ctrl(b_ctrl),
    .retire(b_retire), .inflight(b_inflight));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_a(input string tag, input int k, input logic v, input logic [7:0] c);
    chk({tag, " valid"}, 32'(a_valid[k]), 32'(v));
    chk({tag, " ctrl"}, 32'(a_ctrl[k*8 +: 8]), 32'(c));
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctrl = 8'h00; stall = 3'b000; flush = 3'b000;
    step; step;
    chk("rst valid", 32'(a_valid), 0);
    chk("rst ctrl", 32'(a_ctrl), 0);
    chk("rst inflight", 32'(a_inflight), 0);
    chk("rst retire", 32'(a_retire), 0);
    rst = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h11; step;
    chk_a("s1 c1 s0", 0, 1'b1, 8'h11);
    chk("s1 c1 inflight", 32'(a_inflight), 1);
    chk("s1 c1 retire", 32'(a_retire), 0);
    in_ctrl = 8'h22; step;
    chk("s1 c2 inflight", 32'(a_inflight), 2);
    in_ctrl = 8'h33; step;
    chk_a("s1 c3 s2", 2, 1'b1, 8'h11);
    chk("s1 c3 retire", 32'(a_retire), 1);
    chk("s1 c3 inflight", 32'(a_inflight), 3);
    in_ctrl = 8'h44; step;
    chk_a("s1 c4 s2", 2, 1'b1, 8'h22);
    chk("s1 c4 retire", 32'(a_retire), 1);
    in_ctrl = 8'h55; step;
    chk_a("s1 c5 s2", 2, 1'b1, 8'h33);
    chk("s1 c5 inflight", 32'(a_inflight), 3);
    stall = 3'b011; in_ctrl = 8'h66; step;
    chk_a("st1 s0", 0, 1'b1, 8'h55);
    chk_a("st1 s1", 1, 1'b1, 8'h44);
    chk_a("st1 s2 bubble", 2, 1'b0, 8'h00);
    chk("st1 inflight", 32'(a_inflight), 2);
    chk("st1 retire", 32'(a_retire), 0);
    step;
    chk_a("st2 s0", 0, 1'b1, 8'h55);
    chk_a("st2 s1", 1, 1'b1, 8'h44);
    chk_a("st2 s2 bubble", 2, 1'b0, 8'h00);
    chk("st2 inflight", 32'(a_inflight), 2);
    stall = 3'b000; step;
    chk_a("rel s2", 2, 1'b1, 8'h44);
    chk_a("rel s1", 1, 1'b1, 8'h55);
    chk_a("rel s0", 0, 1'b1, 8'h66);
    chk("rel inflight", 32'(a_inflight), 3);
    in_ctrl = 8'hAA; step;
    in_ctrl = 8'h77; step;
    chk_a("fl pre s1", 1, 1'b1, 8'hAA);
    flush = 3'b010; stall = 3'b011; step;
    chk_a("fl s1", 1, 1'b0, 8'h00);
    chk_a("fl s2", 2, 1'b0, 8'h00);
    chk_a("fl s0", 0, 1'b1, 8'h77);
    chk("fl inflight", 32'(a_inflight), 1);
    flush = 3'b000; step;
    chk_a("fl hold s1", 1, 1'b0, 8'h00);
    chk("fl hold inflight", 32'(a_inflight), 1);
    stall = 3'b000; in_ctrl = 8'hFF; step;
    chk("km s0", 32'(b_ctrl[7:0]), 32'h0FF);
    step;
    chk("km s1", 32'(b_ctrl[15:8]), 32'h0FF);
    step;
    chk("km s2", 32'(b_ctrl[23:16]), 32'h00F);
    chk("km s2 valid", 32'(b_valid[2]), 1);
    chk_a("km full s2", 2, 1'b1, 8'hFF);
    in_valid = 1'b0; in_ctrl = 8'h5A; step;
    chk_a("inv s0", 0, 1'b0, 8'h00);
    chk("inv b s0", 32'(b_ctrl[7:0]), 0);
    chk("inv inflight", 32'(a_inflight), 2);
    in_valid = 1'b1; in_ctrl = 8'hC1; step;
    in_ctrl = 8'hC2; step;
    in_ctrl = 8'hC3; step;
    chk("rm full inflight", 32'(a_inflight), 3);
    stall = 3'b111; #1;
    chk("rm stalled retire", 32'(a_retire), 0);
    rst = 1'b1; in_ctrl = 8'hD1; step;
    chk("rm valid", 32'(a_valid), 0);
    chk("rm ctrl", 32'(a_ctrl), 0);
    chk("rm inflight", 32'(a_inflight), 0);
    chk("rm retire", 32'(a_retire), 0);
    rst = 1'b0; stall = 3'b000; in_ctrl = 8'hE1; step;
    chk_a("rf s0", 0, 1'b1, 8'hE1);
    chk("rf inflight1", 32'(a_inflight), 1);
    in_ctrl = 8'hE2; step;
    in_ctrl = 8'hE3; step;
    chk_a("rf s2", 2, 1'b1, 8'hE1);
    chk("rf inflight3", 32'(a_inflight), 3);
    chk("rf retire", 32'(a_retire), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
